// File: rtl/op_sequencer_pkg.sv
// rtl/op_sequencer_pkg.sv - shared opcode/state types for the MUL/DIV/SQRT front-end sequencer
// Contents: opc_t opcode encoding, seq_state_t FSM states, DEFAULT_TIMEOUT.
package op_sequencer_pkg;

    typedef enum logic [1:0] {
        MUL  = 2'd0,
        DIV  = 2'd1,
        SQRT = 2'd2,
        RSVD = 2'd3
    } opc_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_B    = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } seq_state_t;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/op_sequencer_rise_detect.sv
// rtl/op_sequencer_rise_detect.sv - rising-edge detector for the slow load strobe
// Ports: clk, rst (sync, active-high), i_sig level input, o_rise one-cycle pulse.
// The history register resets to 1 so a level already high during reset never
// produces a pulse once reset is released.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig_q <= 1'b1;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/op_sequencer.sv
// rtl/op_sequencer.sv - operand/opcode capture and start/done handshake ahead of the iterative MUL/DIV/SQRT control unit
// Optional feature macro: OP_TIMEOUT_EN (bounded WAIT_DONE dwell of TIMEOUT_CYCLES).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load                level strobe, rising edge acted on
//   data_in, opc_in     operand bus and opcode sampled on an accepted load edge
//   done, result_in     completion pulse and result from the datapath
//   start, opc_code     one-cycle start pulse and stable opcode to control
//   op_a, op_b          captured operands
//   result, result_valid latched result and its valid flag
//   busy, err           not-IDLE indicator, sticky error flag
module op_sequencer
    import op_sequencer_pkg::*;
#(
    parameter int DW             = 16,
    parameter int RW             = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] data_in,
    input  logic [1:0]    opc_in,
    input  logic          done,
    input  logic [RW-1:0] result_in,
    output logic          start,
    output logic [1:0]    opc_code,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic [RW-1:0] result,
    output logic          result_valid,
    output logic          busy,
    output logic          err
);

    seq_state_t    r_state;
    seq_state_t    w_next_state;
    opc_t          w_opc;
    logic          w_rise;
    logic          w_timeout;
    logic [1:0]    r_opc_code;
    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;
    logic [RW-1:0] r_result;
    logic          r_result_valid;
    logic          r_err;

    assign w_opc = opc_t'(opc_in);

    rise_detect u_rise_detect (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (load),
        .o_rise (w_rise)
    );

`ifdef OP_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] r_to_cnt;

    // A done arriving in the expiry cycle takes priority over the timeout.
    assign w_timeout = (r_state == WAIT_DONE) && !done && (r_to_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_to_cnt <= '0;
        end else if ((r_state == WAIT_DONE) && !done && !w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    case (w_opc)
                        SQRT:    w_next_state = ISSUE;
                        RSVD:    w_next_state = IDLE;
                        default: w_next_state = LOAD_B;
                    endcase
                end
            end
            LOAD_B: begin
                if (w_rise) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done || w_timeout) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_opc_code     <= '0;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_op_a         <= data_in;
                        r_opc_code     <= opc_in;
                        r_result_valid <= 1'b0;
                        r_err          <= (w_opc == RSVD);
                        // SQRT is unary; the second operand is defined as zero.
                        if (w_opc == SQRT) begin
                            r_op_b <= '0;
                        end
                    end
                end
                LOAD_B: begin
                    if (w_rise) begin
                        r_op_b <= data_in;
                    end
                end
                ISSUE: begin
                    if (w_rise) begin
                        r_err <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (w_rise || w_timeout) begin
                        r_err <= 1'b1;
                    end
                    if (done) begin
                        r_result       <= result_in;
                        r_result_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign start        = (r_state == ISSUE);
    assign busy         = (r_state != IDLE);
    assign opc_code     = r_opc_code;
    assign op_a         = r_op_a;
    assign op_b         = r_op_b;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign err          = r_err;

endmodule

// File: tb/tb_op_sequencer.sv
// tb/tb_op_sequencer.sv - self-checking bench for op_sequencer with a done/result responder and result scoreboard
module tb_op_sequencer;

    localparam int DW = 16;
    localparam int RW = 32;
    localparam int TO = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [1:0]    opc_in = '0;
    logic          done = 1'b0;
    logic [RW-1:0] result_in = '0;
    logic          start;
    logic [1:0]    opc_code;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [RW-1:0] result;
    logic          result_valid;
    logic          busy;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;

    bit            resp_en = 1'b1;
    logic [RW-1:0] resp_val = '0;
    logic [RW-1:0] exp_q[$];

    op_sequencer #(.DW(DW), .RW(RW), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .data_in      (data_in),
        .opc_in       (opc_in),
        .done         (done),
        .result_in    (result_in),
        .start        (start),
        .opc_code     (opc_code),
        .op_a         (op_a),
        .op_b         (op_b),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start === 1'b1) start_cnt++;
    end

    // Datapath stand-in: answers each start with done + result four cycles later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (start === 1'b1 && resp_en) begin
                repeat (4) @(posedge clk);
                #1;
                done      = 1'b1;
                result_in = resp_val;
                @(posedge clk);
                #1;
                done      = 1'b0;
                result_in = '0;
            end
        end
    end

    function automatic logic [RW-1:0] model(input logic [1:0] opc, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [RW-1:0] r;
        r = '0;
        case (opc)
            2'd0: r = RW'(a) * RW'(b);
            2'd1: r = (b == 0) ? '1 : RW'(a / b);
            2'd2: begin
                for (int i = 0; i <= 255; i++) begin
                    if (i * i <= int'(a)) r = RW'(i);
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [DW-1:0] d, input logic [1:0] opc);
        data_in = d;
        opc_in  = opc;
        load    = 1'b1;
        tick();
        tick();
        load    = 1'b0;
        tick();
    endtask

    task automatic wait_rv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (result_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; data_in = 16'h5555; opc_in = 2'd2;
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();
        load = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_tests++; if (start_cnt !== 0) begin n_fail++; $display("FAIL reset_start got=%0d exp=0", start_cnt); end
        n_tests++; if (op_a !== 16'h0) begin n_fail++; $display("FAIL reset_op_a got=%0h exp=0", op_a); end
        n_tests++; if ({result_valid, err, opc_code} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags got=%0b exp=0", {result_valid, err, opc_code});
        end
    endtask

    task automatic test_mul();
        bit ok;
        int s0;
        s0 = start_cnt;
        resp_val = 32'd63;
        exp_q.push_back(32'd63);
        do_load(16'd7, 2'd0);
        do_load(16'd9, 2'd0);
        wait_rv(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL mul_timeout got=no_result exp=result_valid"); end
        n_tests++; if (result !== exp_q.pop_front()) begin n_fail++; $display("FAIL mul_result got=%0d exp=63", result); end
        n_tests++; if (op_a !== 16'd7 || op_b !== 16'd9) begin
            n_fail++; $display("FAIL mul_ops got=%0d,%0d exp=7,9", op_a, op_b);
        end
        n_tests++; if (opc_code !== 2'd0) begin n_fail++; $display("FAIL mul_opc got=%0d exp=0", opc_code); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy got=%0b exp=0", busy); end
        n_tests++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL mul_starts got=%0d exp=1", start_cnt - s0); end
    endtask

    task automatic test_sqrt();
        bit ok;
        resp_val = 32'd12;
        exp_q.push_back(32'd12);
        data_in = 16'd144; opc_in = 2'd2; load = 1'b1;
        tick();
        n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL sqrt_latency got=%0b exp=1", start); end
        tick();
        load = 1'b0;
        wait_rv(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL sqrt_timeout got=no_result exp=result_valid"); end
        n_tests++; if (result !== exp_q.pop_front()) begin n_fail++; $display("FAIL sqrt_result got=%0d exp=12", result); end
        n_tests++; if (op_b !== 16'd0 || op_a !== 16'd144) begin
            n_fail++; $display("FAIL sqrt_ops got=%0d,%0d exp=144,0", op_a, op_b);
        end
        n_tests++; if (opc_code !== 2'd2) begin n_fail++; $display("FAIL sqrt_opc got=%0d exp=2", opc_code); end
    endtask

    task automatic test_rsvd();
        int s0;
        bit ok;
        s0 = start_cnt;
        do_load(16'h33, 2'd3);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL rsvd_err got=%0b exp=1", err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rsvd_busy got=%0b exp=0", busy); end
        n_tests++; if (start_cnt !== s0) begin n_fail++; $display("FAIL rsvd_start got=%0d exp=%0d", start_cnt, s0); end
        resp_val = 32'd15;
        exp_q.push_back(32'd15);
        do_load(16'd3, 2'd0);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rsvd_clear got=%0b exp=0", err); end
        do_load(16'd5, 2'd0);
        wait_rv(ok);
        n_tests++; if (!ok || result !== exp_q.pop_front()) begin
            n_fail++; $display("FAIL rsvd_next_mul got=%0d exp=15", result);
        end
    endtask

    task automatic test_overrun_and_reset();
        int s0;
        resp_en = 1'b0;
        do_load(16'd4, 2'd1);
        do_load(16'd2, 2'd1);
        do_load(16'hAA, 2'd0);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL overrun_err got=%0b exp=1", err); end
        n_tests++; if (op_a !== 16'd4 || op_b !== 16'd2 || opc_code !== 2'd1) begin
            n_fail++; $display("FAIL overrun_hold got=%0d,%0d,%0d exp=4,2,1", op_a, op_b, opc_code);
        end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL overrun_busy got=%0b exp=1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s0 = start_cnt;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
        n_tests++; if ({start, opc_code, op_a, op_b, result, result_valid, err} !== '0) begin
            n_fail++; $display("FAIL midrst_outputs got=%0h exp=0", {start, opc_code, op_a, op_b, result, result_valid, err});
        end
        tick();
        n_tests++; if (start_cnt !== s0 || start !== 1'b0) begin
            n_fail++; $display("FAIL midrst_start got=%0d exp=%0d", start_cnt, s0);
        end
        resp_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [1:0]    t_opc[4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic [DW-1:0] t_a[4]   = '{16'd300, 16'd100, 16'd50, 16'hFFFF};
        logic [DW-1:0] t_b[4]   = '{16'd200, 16'd7, 16'd0, 16'hFFFF};
        bit ok;
        for (int i = 0; i < 4; i++) begin
            resp_val = model(t_opc[i], t_a[i], t_b[i]);
            exp_q.push_back(resp_val);
            do_load(t_a[i], t_opc[i]);
            if (t_opc[i] != 2'd2) do_load(t_b[i], t_opc[i]);
            wait_rv(ok);
            n_tests++; if (!ok || result !== exp_q.pop_front()) begin
                n_fail++; $display("FAIL b2b_result[%0d] got=%0h exp=%0h", i, result, resp_val);
            end
            n_tests++; if (op_a !== t_a[i] || op_b !== t_b[i] || opc_code !== t_opc[i]) begin
                n_fail++; $display("FAIL b2b_ops[%0d] got=%0h,%0h,%0d exp=%0h,%0h,%0d", i, op_a, op_b, opc_code,
                                   t_a[i], t_b[i], t_opc[i]);
            end
        end
    endtask

`ifdef OP_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        resp_en = 1'b0;
        do_load(16'd2, 2'd0);
        do_load(16'd3, 2'd0);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL timeout_exit got=busy exp=idle"); end
        n_tests++; if (err !== 1'b1 || result_valid !== 1'b0) begin
            n_fail++; $display("FAIL timeout_flags got=err%0b,rv%0b exp=err1,rv0", err, result_valid);
        end
        resp_en = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_mul();
        test_sqrt();
        test_rsvd();
        test_overrun_and_reset();
        test_back_to_back();
`ifdef OP_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
